// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu -- MEM-stage load/store unit.
//
// Turns the EX/MEM load/store request into one word-addressed transaction on
// a variable-latency data bus. It stalls the pipeline until the transaction
// ends, then returns the sign- or zero-extended load result.
//
// Ports:
//   clk, reset     clock; synchronous active-high reset
//   mem_read       load request from EX/MEM
//   mem_write      store request from EX/MEM
//   addr           byte address (DM_ADDRESS bits)
//   wr_data        store data
//   func3          RV32I access size / sign encoding
//   rd_data        extended load result, registered; held until the next good load
//   stall          freezes the upstream pipeline while high
//   access_fault   one-cycle pulse: illegal request (IDLE) or bus timeout (DONE)
//   bus_req        registered transaction request
//   bus_we         1 = write
//   bus_addr       word address, addr[DM_ADDRESS-1:2]
//   bus_be         byte enables
//   bus_wdata      lane-aligned store data
//   bus_rdata      read data, valid with bus_ack
//   bus_ack        one-cycle completion strobe
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | evaluate EX/MEM request; fault illegal ones, launch legal ones
// REQ    | bus_req held; wait for bus_ack or the timeout
// DONE   | one stall-free cycle so the pipeline advances past the access

module mem_stage_lsu #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [DM_ADDRESS-1:0] addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [2:0]            func3,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  stall,
    output logic                  access_fault,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [DM_ADDRESS-3:0] bus_addr,
    output logic [3:0]            bus_be,
    output logic [DATA_W-1:0]     bus_wdata,
    input  logic [DATA_W-1:0]     bus_rdata,
    input  logic                  bus_ack
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Value the counter holds during the last REQ cycle allowed before abort.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t state, state_next;

    logic [7:0]        req_cnt;
    logic              fault_q;
    logic [2:0]        ld_func3;
    logic [1:0]        ld_off;

    logic              req_any;
    logic              ld_ok;
    logic              st_ok;
    logic              misaligned;
    logic              illegal;
    logic              legal;
    logic              timed_out;
    logic [3:0]        be_next;
    logic [DATA_W-1:0] wdata_next;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [DATA_W-1:0] ld_ext;

    // ---------------------------------------------------------------
    // Request decode
    // ---------------------------------------------------------------
    always_comb begin
        ld_ok = 1'b0;
        case (func3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ld_ok = 1'b1;
            default:                                ld_ok = 1'b0;
        endcase
    end

    assign st_ok      = (func3[2] == 1'b0) && (func3[1:0] != 2'b11);
    assign misaligned = ((func3[1:0] == 2'b01) && addr[0]) ||
                        ((func3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    assign req_any    = mem_read | mem_write;

    // A simultaneous read+write is illegal whatever func3 says.
    assign illegal = req_any &&
                     ((mem_read && mem_write) ||
                      (mem_read  && !ld_ok)   ||
                      (mem_write && !st_ok)   ||
                      misaligned);
    assign legal   = req_any && !illegal;

    assign timed_out = (req_cnt == TO_LAST);

    // Lane steering, shared by loads and stores.
    always_comb begin
        be_next    = 4'b1111;
        wdata_next = wr_data;
        case (func3[1:0])
            2'b00: begin
                be_next    = 4'b0001 << addr[1:0];
                wdata_next = {(DATA_W/8){wr_data[7:0]}};
            end
            2'b01: begin
                be_next    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_next = {(DATA_W/16){wr_data[15:0]}};
            end
            default: begin
                be_next    = 4'b1111;
                wdata_next = wr_data;
            end
        endcase
    end

    // Load extension uses the offset/func3 latched at launch, since EX/MEM
    // contents are not guaranteed stable by the time the ack arrives.
    assign ld_byte = bus_rdata[{ld_off, 3'b000} +: 8];
    assign ld_half = bus_rdata[{ld_off[1], 4'b0000} +: 16];

    always_comb begin
        ld_ext = bus_rdata;
        case (ld_func3)
            3'b000:  ld_ext = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{(DATA_W-16){ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {{(DATA_W-8){1'b0}}, ld_byte};
            3'b101:  ld_ext = {{(DATA_W-16){1'b0}}, ld_half};
            default: ld_ext = bus_rdata;
        endcase
    end

    // ---------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------------------------------------------------------
    // FSM: next state
    // ---------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (legal) begin
                    state_next = S_REQ;
                end
            end
            S_REQ: begin
                // An ack in the final allowed cycle still completes normally.
                if (bus_ack || timed_out) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // FSM: outputs
    // ---------------------------------------------------------------
    always_comb begin
        stall        = 1'b0;
        access_fault = 1'b0;
        case (state)
            S_IDLE: begin
                stall        = legal;
                access_fault = illegal;
            end
            S_REQ: begin
                stall = 1'b1;
            end
            S_DONE: begin
                access_fault = fault_q;
            end
            default: begin
                stall        = 1'b0;
                access_fault = 1'b0;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Bus registers, timeout counter and load result
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data   <= '0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= '0;
            bus_wdata <= '0;
            req_cnt   <= '0;
            fault_q   <= 1'b0;
            ld_func3  <= '0;
            ld_off    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (legal) begin
                        bus_req   <= 1'b1;
                        bus_we    <= mem_write;
                        bus_addr  <= addr[DM_ADDRESS-1:2];
                        bus_be    <= be_next;
                        bus_wdata <= wdata_next;
                        ld_func3  <= func3;
                        ld_off    <= addr[1:0];
                        req_cnt   <= '0;
                        fault_q   <= 1'b0;
                    end
                end
                S_REQ: begin
                    req_cnt <= req_cnt + 8'd1;
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        if (!bus_we) begin
                            rd_data <= ld_ext;
                        end
                    end else if (timed_out) begin
                        bus_req <= 1'b0;
                        fault_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    fault_q <= 1'b0;
                end
                default: begin
                    bus_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
